// File: rtl/wb_regfile_if.sv
// Bundle of the write-back stage signals. The master side is the MEM/WB register
// together with the decode read ports. The slave side is wb_regfile.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              regwrite_in;
  logic              memtoreg_in;
  logic [DATA_W-1:0] read_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [4:0]        write_reg_in;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [4:0]        wb_reg;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output regwrite_in, memtoreg_in, read_data_in, alu_result_in, write_reg_in,
           rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, wb_reg, retire_count
  );

  modport slave (
    input  regwrite_in, memtoreg_in, read_data_in, alu_result_in, write_reg_in,
           rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, wb_reg, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// MIPS write-back stage with a 32-entry register file. It provides two combinational
// read ports with write-through bypass and counts committed writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          reset,
  wb_regfile_if.slave  bus
);
  localparam int NUM_RD = 2;

  logic [DATA_W-1:0]             regs_q [32];
  logic [DATA_W-1:0]             regs_d [32];
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]             wb_data;
  logic                          wb_we;
  logic [NUM_RD-1:0][4:0]        raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  // wb_we is gated by reset, so the state update below never sees a write during reset.
  always_comb begin
    wb_data = bus.memtoreg_in ? bus.read_data_in : bus.alu_result_in;
    wb_we   = bus.regwrite_in & (bus.write_reg_in != 5'd0) & ~reset;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[bus.write_reg_in] = wb_data;
    cnt_d = cnt_q + CNT_W'(wb_we);
  end

  // Port 0 is rs and port 1 is rt. A same-cycle write to the addressed register is bypassed.
  always_comb begin
    raddr = {bus.rt_addr, bus.rs_addr};
    for (int p = 0; p < NUM_RD; p++) begin
      rdata[p] = '0;
      if (!reset && raddr[p] != 5'd0) begin
        if (wb_we && raddr[p] == bus.write_reg_in) rdata[p] = wb_data;
        else                                       rdata[p] = regs_q[raddr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.wb_data      = wb_data;
  assign bus.wb_we        = wb_we;
  assign bus.wb_reg       = bus.write_reg_in;
  assign bus.rs_data      = rdata[0];
  assign bus.rt_data      = rdata[1];
  assign bus.retire_count = cnt_q;
endmodule
